// File: rtl/scr1_mem_arb_if.sv
// Shared memory-port types and the request/response bundle used on every arbiter port.
// The master side drives the request fields; the slave side returns ack, read data and response.
package scr1_mem_pkg;
   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      SCR1_MEM_WIDTH_BYTE  = 2'b00,
      SCR1_MEM_WIDTH_HWORD = 2'b01,
      SCR1_MEM_WIDTH_WORD  = 2'b10
   } type_scr1_mem_width_e;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;
endpackage

interface scr1_mem_arb_if #(
   parameter int ADDR_W = 32
);
   import scr1_mem_pkg::*;

   logic                 req;
   type_scr1_mem_cmd_e   cmd;
   type_scr1_mem_width_e width;
   logic [ADDR_W-1:0]    addr;
   logic [31:0]          wdata;
   logic                 req_ack;
   logic [31:0]          rdata;
   type_scr1_mem_resp_e  resp;

   modport master (output req, cmd, width, addr, wdata,
                   input  req_ack, rdata, resp);
   modport slave  (input  req, cmd, width, addr, wdata,
                   output req_ack, rdata, resp);
endinterface

// File: rtl/scr1_mem_arb.sv
// Merges the IMEM and DMEM ports onto one bridge port; an in-order FIFO of owner IDs
// steers each response back to the master whose request produced it.
module scr1_mem_arb
   import scr1_mem_pkg::*;
#(
   parameter int SCR1_ARB_OUTST      = 4,
   parameter int SCR1_ADDR_WIDTH     = 32,
   parameter bit SCR1_ARB_DMEM_PRIO  = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   scr1_mem_arb_if.slave  imem,
   scr1_mem_arb_if.slave  dmem,
   scr1_mem_arb_if.master mem,
   output logic           arb_idle,
   output logic           arb_unexp_resp
);

   localparam int   PTR_W   = $clog2(SCR1_ARB_OUTST);
   localparam int   CNT_W   = PTR_W + 1;
   localparam logic ID_IMEM = 1'b0;
   localparam logic ID_DMEM = 1'b1;

   logic                       fifo_q [SCR1_ARB_OUTST];
   logic                       fifo_d [SCR1_ARB_OUTST];
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]           count_q, count_d;
   logic                       rr_prio_q, rr_prio_d;
   logic                       lock_vld_q, lock_vld_d;
   logic                       lock_id_q, lock_id_d;

   logic                       grant_vld, grant_id, locked_req;
   logic                       fifo_full, fifo_empty, accept;
   logic                       resp_vld, route, head_id;
   logic [SCR1_ADDR_WIDTH-1:0] fwd_addr;

   assign locked_req = (lock_id_q == ID_DMEM) ? dmem.req : imem.req;

   // A stalled request keeps its grant so the bridge never sees the request change under it.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = ID_IMEM;
      if (lock_vld_q && locked_req) begin
         grant_vld = 1'b1;
         grant_id  = lock_id_q;
      end else if (imem.req && dmem.req) begin
         grant_vld = 1'b1;
         grant_id  = SCR1_ARB_DMEM_PRIO ? ID_DMEM : rr_prio_q;
      end else if (imem.req) begin
         grant_vld = 1'b1;
         grant_id  = ID_IMEM;
      end else if (dmem.req) begin
         grant_vld = 1'b1;
         grant_id  = ID_DMEM;
      end
   end

   always_comb begin
      mem.cmd   = SCR1_MEM_CMD_RD;
      mem.width = SCR1_MEM_WIDTH_BYTE;
      mem.wdata = '0;
      fwd_addr  = '0;
      if (grant_vld) begin
         if (grant_id == ID_DMEM) begin
            mem.cmd   = dmem.cmd;
            mem.width = dmem.width;
            mem.wdata = dmem.wdata;
            fwd_addr  = dmem.addr;
         end else begin
            mem.cmd   = imem.cmd;
            mem.width = imem.width;
            mem.wdata = imem.wdata;
            fwd_addr  = imem.addr;
         end
      end
      mem.addr = fwd_addr;
   end

   assign fifo_full    = (count_q == CNT_W'(SCR1_ARB_OUTST));
   assign fifo_empty   = (count_q == '0);
   assign mem.req      = grant_vld & ~fifo_full & ~rst;
   assign accept       = mem.req & mem.req_ack;
   assign imem.req_ack = accept & (grant_id == ID_IMEM);
   assign dmem.req_ack = accept & (grant_id == ID_DMEM);

   assign resp_vld       = (mem.resp != SCR1_MEM_RESP_NOTRDY);
   assign route          = resp_vld & ~fifo_empty;
   assign head_id        = fifo_q[rd_ptr_q];
   assign arb_unexp_resp = resp_vld & fifo_empty & ~rst;
   assign arb_idle       = fifo_empty;

   always_comb begin
      imem.resp  = SCR1_MEM_RESP_NOTRDY;
      imem.rdata = '0;
      dmem.resp  = SCR1_MEM_RESP_NOTRDY;
      dmem.rdata = '0;
      if (route) begin
         if (head_id == ID_DMEM) begin
            dmem.resp  = mem.resp;
            dmem.rdata = mem.rdata;
         end else begin
            imem.resp  = mem.resp;
            imem.rdata = mem.rdata;
         end
      end
   end

   always_comb begin
      fifo_d     = fifo_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      rr_prio_d  = rr_prio_q;
      lock_vld_d = lock_vld_q;
      lock_id_d  = lock_id_q;
      if (accept) begin
         fifo_d[wr_ptr_q] = grant_id;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
         rr_prio_d        = ~grant_id;
         lock_vld_d       = 1'b0;
      end else if (mem.req) begin
         lock_vld_d = 1'b1;
         lock_id_d  = grant_id;
      end else if (lock_vld_q && !locked_req) begin
         lock_vld_d = 1'b0;
      end
      if (route) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(accept) - CNT_W'(route);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SCR1_ARB_OUTST; i++) begin
            fifo_q[i] <= ID_IMEM;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rr_prio_q  <= ID_IMEM;
         lock_vld_q <= 1'b0;
         lock_id_q  <= ID_IMEM;
      end else begin
         fifo_q     <= fifo_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rr_prio_q  <= rr_prio_d;
         lock_vld_q <= lock_vld_d;
         lock_id_q  <= lock_id_d;
      end
   end

endmodule

// File: tb/tb_scr1_mem_arb.sv
// Directed bench for scr1_mem_arb: expected response owners are queued when a request is
// expected to be accepted and popped when the bench drives the matching bridge response.
module tb_scr1_mem_arb;
   import scr1_mem_pkg::*;

   localparam int ADDR_W = 32;

   logic clk = 1'b0;
   logic rst;
   logic arb_idle;
   logic arb_unexp_resp;
   int   checks = 0;
   int   errors = 0;
   bit   owner_q[$];

   scr1_mem_arb_if #(.ADDR_W(ADDR_W)) imem_bus();
   scr1_mem_arb_if #(.ADDR_W(ADDR_W)) dmem_bus();
   scr1_mem_arb_if #(.ADDR_W(ADDR_W)) mem_bus();

   scr1_mem_arb #(
      .SCR1_ARB_OUTST     (4),
      .SCR1_ADDR_WIDTH    (ADDR_W),
      .SCR1_ARB_DMEM_PRIO (1'b0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem           (imem_bus),
      .dmem           (dmem_bus),
      .mem            (mem_bus),
      .arb_idle       (arb_idle),
      .arb_unexp_resp (arb_unexp_resp)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed no finish expected finish before timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                input logic dreq, input logic [31:0] daddr, input logic ack);
      imem_bus.req     = ireq;
      imem_bus.addr    = iaddr;
      dmem_bus.req     = dreq;
      dmem_bus.addr    = daddr;
      mem_bus.req_ack  = ack;
   endtask

   task automatic driveResp(input type_scr1_mem_resp_e r, input logic [31:0] d);
      mem_bus.resp  = r;
      mem_bus.rdata = d;
   endtask

   // Expected winner comes from the bench's own arbitration model; the owner is queued for routing.
   task automatic checkGrant(input string tag, input bit owner, input logic [31:0] addr);
      checkOutput({tag, "_mem_req"}, 32'(mem_bus.req), 32'd1);
      checkOutput({tag, "_mem_addr"}, mem_bus.addr, addr);
      checkOutput({tag, "_imem_ack"}, 32'(imem_bus.req_ack), owner ? 32'd0 : 32'd1);
      checkOutput({tag, "_dmem_ack"}, 32'(dmem_bus.req_ack), owner ? 32'd1 : 32'd0);
      owner_q.push_back(owner);
   endtask

   task automatic checkNoAccept(input string tag);
      checkOutput({tag, "_mem_req"}, 32'(mem_bus.req), 32'd0);
      checkOutput({tag, "_imem_ack"}, 32'(imem_bus.req_ack), 32'd0);
      checkOutput({tag, "_dmem_ack"}, 32'(dmem_bus.req_ack), 32'd0);
   endtask

   task automatic checkResp(input string tag, input type_scr1_mem_resp_e r, input logic [31:0] d);
      bit owner;
      if (owner_q.size() == 0) begin
         checks++;
         errors++;
         $error("[TB] FAIL %s: observed empty scoreboard expected pending owner", tag);
         return;
      end
      owner = owner_q.pop_front();
      checkOutput({tag, "_iresp"},  32'(imem_bus.resp),  owner ? 32'(SCR1_MEM_RESP_NOTRDY) : 32'(r));
      checkOutput({tag, "_irdata"}, imem_bus.rdata,       owner ? 32'd0 : d);
      checkOutput({tag, "_dresp"},  32'(dmem_bus.resp),  owner ? 32'(r) : 32'(SCR1_MEM_RESP_NOTRDY));
      checkOutput({tag, "_drdata"}, dmem_bus.rdata,       owner ? d : 32'd0);
      checkOutput({tag, "_unexp"},  32'(arb_unexp_resp), 32'd0);
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      driveResp(SCR1_MEM_RESP_NOTRDY, 32'd0);
      advance();
      advance();
      imem_bus.req = 1'b1;
      settle();
      checkOutput("rst_mem_req", 32'(mem_bus.req), 32'd0);
      checkOutput("rst_idle", 32'(arb_idle), 32'd1);
      checkOutput("rst_unexp", 32'(arb_unexp_resp), 32'd0);
      advance();
      rst = 1'b0;
      imem_bus.req = 1'b0;
      owner_q.delete();
   endtask

   initial begin
      rst = 1'b1;
      imem_bus.cmd   = SCR1_MEM_CMD_RD;
      imem_bus.width = SCR1_MEM_WIDTH_WORD;
      imem_bus.wdata = 32'd0;
      dmem_bus.cmd   = SCR1_MEM_CMD_RD;
      dmem_bus.width = SCR1_MEM_WIDTH_WORD;
      dmem_bus.wdata = 32'd0;
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      driveResp(SCR1_MEM_RESP_NOTRDY, 32'd0);
      doReset();

      // Single IMEM read, response two cycles after acceptance.
      applyStimulus(1'b1, 32'h100, 1'b0, 32'd0, 1'b1);
      settle();
      checkGrant("rd", 1'b0, 32'h100);
      checkOutput("rd_idle_before", 32'(arb_idle), 32'd1);
      advance();
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      settle();
      checkOutput("rd_busy", 32'(arb_idle), 32'd0);
      checkOutput("rd_noreq", 32'(mem_bus.req), 32'd0);
      checkOutput("rd_addr_zero", mem_bus.addr, 32'd0);
      advance();
      driveResp(SCR1_MEM_RESP_RDY_OK, 32'hDEADBEEF);
      settle();
      checkResp("rd_resp", SCR1_MEM_RESP_RDY_OK, 32'hDEADBEEF);
      advance();
      driveResp(SCR1_MEM_RESP_NOTRDY, 32'd0);
      settle();
      checkOutput("rd_idle_after", 32'(arb_idle), 32'd1);
      checkOutput("rd_iresp_clear", 32'(imem_bus.resp), 32'(SCR1_MEM_RESP_NOTRDY));
      advance();

      // DMEM write fields pass through untouched.
      dmem_bus.cmd   = SCR1_MEM_CMD_WR;
      dmem_bus.width = SCR1_MEM_WIDTH_BYTE;
      dmem_bus.wdata = 32'hA5A5_5A5A;
      applyStimulus(1'b0, 32'd0, 1'b1, 32'h80, 1'b1);
      settle();
      checkGrant("wr", 1'b1, 32'h80);
      checkOutput("wr_cmd", 32'(mem_bus.cmd), 32'(SCR1_MEM_CMD_WR));
      checkOutput("wr_width", 32'(mem_bus.width), 32'(SCR1_MEM_WIDTH_BYTE));
      checkOutput("wr_wdata", mem_bus.wdata, 32'hA5A5_5A5A);
      advance();
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      dmem_bus.cmd   = SCR1_MEM_CMD_RD;
      dmem_bus.width = SCR1_MEM_WIDTH_WORD;
      driveResp(SCR1_MEM_RESP_RDY_OK, 32'h0000_1234);
      settle();
      checkResp("wr_resp", SCR1_MEM_RESP_RDY_OK, 32'h0000_1234);
      advance();
      driveResp(SCR1_MEM_RESP_NOTRDY, 32'd0);

      // Round-robin contention fills the FIFO, then full / pop / push+pop behaviour.
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'h200, 1'b1, 32'h300, 1'b1);
         settle();
         checkGrant($sformatf("rr%0d", i), i[0], i[0] ? 32'h300 : 32'h200);
         advance();
      end
      settle();
      checkNoAccept("full");
      checkOutput("full_idle", 32'(arb_idle), 32'd0);
      advance();
      driveResp(SCR1_MEM_RESP_RDY_OK, 32'h1111_0000);
      settle();
      checkNoAccept("full_pop");
      checkResp("full_pop", SCR1_MEM_RESP_RDY_OK, 32'h1111_0000);
      advance();
      driveResp(SCR1_MEM_RESP_RDY_OK, 32'h2222_0000);
      settle();
      checkResp("pushpop", SCR1_MEM_RESP_RDY_OK, 32'h2222_0000);
      checkGrant("pushpop", 1'b0, 32'h200);
      advance();
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         driveResp(SCR1_MEM_RESP_RDY_OK, 32'h3000 + 32'(i));
         settle();
         checkResp($sformatf("drain%0d", i), SCR1_MEM_RESP_RDY_OK, 32'h3000 + 32'(i));
         advance();
      end
      driveResp(SCR1_MEM_RESP_NOTRDY, 32'd0);
      settle();
      checkOutput("drain_idle", 32'(arb_idle), 32'd1);
      advance();

      // Stalled DMEM request holds its grant against a competing IMEM request.
      doReset();
      applyStimulus(1'b0, 32'd0, 1'b1, 32'h400, 1'b0);
      for (int i = 0; i < 3; i++) begin
         settle();
         checkOutput($sformatf("stall%0d_mem_req", i), 32'(mem_bus.req), 32'd1);
         checkOutput($sformatf("stall%0d_addr", i), mem_bus.addr, 32'h400);
         checkOutput($sformatf("stall%0d_iack", i), 32'(imem_bus.req_ack), 32'd0);
         checkOutput($sformatf("stall%0d_dack", i), 32'(dmem_bus.req_ack), 32'd0);
         advance();
         applyStimulus(1'b1, 32'h500, 1'b1, 32'h400, 1'b0);
      end
      applyStimulus(1'b1, 32'h500, 1'b1, 32'h400, 1'b1);
      settle();
      checkGrant("lock_release", 1'b1, 32'h400);
      advance();
      applyStimulus(1'b1, 32'h500, 1'b1, 32'h404, 1'b1);
      settle();
      checkGrant("lock_next", 1'b0, 32'h500);
      advance();
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      driveResp(SCR1_MEM_RESP_RDY_OK, 32'h4444_4444);
      settle();
      checkResp("lock_resp0", SCR1_MEM_RESP_RDY_OK, 32'h4444_4444);
      advance();
      driveResp(SCR1_MEM_RESP_RDY_ER, 32'h5555_5555);
      settle();
      checkResp("lock_resp1", SCR1_MEM_RESP_RDY_ER, 32'h5555_5555);
      advance();
      driveResp(SCR1_MEM_RESP_NOTRDY, 32'd0);

      // Response with nothing outstanding is flagged for one cycle and not routed.
      doReset();
      driveResp(SCR1_MEM_RESP_RDY_ER, 32'h0000_0055);
      settle();
      checkOutput("unexp_flag", 32'(arb_unexp_resp), 32'd1);
      checkOutput("unexp_iresp", 32'(imem_bus.resp), 32'(SCR1_MEM_RESP_NOTRDY));
      checkOutput("unexp_dresp", 32'(dmem_bus.resp), 32'(SCR1_MEM_RESP_NOTRDY));
      checkOutput("unexp_irdata", imem_bus.rdata, 32'd0);
      checkOutput("unexp_drdata", dmem_bus.rdata, 32'd0);
      checkOutput("unexp_idle", 32'(arb_idle), 32'd1);
      advance();
      driveResp(SCR1_MEM_RESP_NOTRDY, 32'd0);
      settle();
      checkOutput("unexp_clear", 32'(arb_unexp_resp), 32'd0);
      advance();

      // Reset with two requests outstanding discards them and restores IMEM priority.
      applyStimulus(1'b1, 32'h600, 1'b0, 32'd0, 1'b1);
      settle();
      checkGrant("mid0", 1'b0, 32'h600);
      advance();
      applyStimulus(1'b1, 32'h604, 1'b0, 32'd0, 1'b1);
      settle();
      checkGrant("mid1", 1'b0, 32'h604);
      advance();
      rst = 1'b1;
      applyStimulus(1'b1, 32'h608, 1'b0, 32'd0, 1'b1);
      settle();
      checkOutput("mid_rst_mem_req", 32'(mem_bus.req), 32'd0);
      checkOutput("mid_rst_busy", 32'(arb_idle), 32'd0);
      advance();
      rst = 1'b0;
      owner_q.delete();
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      driveResp(SCR1_MEM_RESP_RDY_OK, 32'h0000_0066);
      settle();
      checkOutput("mid_idle", 32'(arb_idle), 32'd1);
      checkOutput("mid_mem_req", 32'(mem_bus.req), 32'd0);
      checkOutput("mid_stale_unexp", 32'(arb_unexp_resp), 32'd1);
      checkOutput("mid_stale_iresp", 32'(imem_bus.resp), 32'(SCR1_MEM_RESP_NOTRDY));
      advance();
      driveResp(SCR1_MEM_RESP_NOTRDY, 32'd0);
      applyStimulus(1'b1, 32'h700, 1'b1, 32'h800, 1'b1);
      settle();
      checkGrant("mid_rr", 1'b0, 32'h700);
      advance();
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      driveResp(SCR1_MEM_RESP_RDY_OK, 32'h0000_0077);
      settle();
      checkResp("mid_resp", SCR1_MEM_RESP_RDY_OK, 32'h0000_0077);
      advance();
      driveResp(SCR1_MEM_RESP_NOTRDY, 32'd0);
      settle();
      checkOutput("final_idle", 32'(arb_idle), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/scr1_mem_arb.md
Name: scr1_mem_arb

Overview:
- Two-master arbiter that merges the IMEM and DMEM core memory ports onto the single core-side request port of the memory AXI bridge.
- Forwards each granted request unchanged, in the same cycle.
- Records the owner of every accepted request in an in-order route FIFO and steers each completed response back to that owner.
- The bridge returns responses strictly in order, so one FIFO of master IDs is sufficient.

Parameters:
SCR1_ARB_OUTST, 4, route FIFO depth = max accepted-but-unanswered requests; power of 2, >=2
SCR1_ADDR_WIDTH, 32, address width of all ports
SCR1_ARB_DMEM_PRIO, 0, 0 = round-robin; 1 = DMEM fixed priority

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_req  in  1  IMEM request valid
imem_cmd  in  type_scr1_mem_cmd_e  IMEM command
imem_width  in  type_scr1_mem_width_e  IMEM access width
imem_addr  in  SCR1_ADDR_WIDTH  IMEM address
imem_wdata  in  32  IMEM write data
imem_req_ack  out  1  IMEM request accepted this cycle
imem_rdata  out  32  IMEM read data
imem_resp  out  type_scr1_mem_resp_e  IMEM response
dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata, dmem_req_ack, dmem_rdata, dmem_resp  (same as imem_*)  DMEM port
mem_req  out  1  request to bridge
mem_cmd  out  type_scr1_mem_cmd_e  forwarded command
mem_width  out  type_scr1_mem_width_e  forwarded width
mem_addr  out  SCR1_ADDR_WIDTH  forwarded address
mem_wdata  out  32  forwarded write data
mem_req_ack  in  1  bridge accepted request
mem_rdata  in  32  bridge read data
mem_resp  in  type_scr1_mem_resp_e  bridge response
arb_idle  out  1  route FIFO empty
arb_unexp_resp  out  1  one-cycle pulse: response arrived with FIFO empty

Behaviour:
- **Clock/reset:** single clock clk; reset rst is synchronous, active-high.
- **Reset state:** route FIFO empty (wr_ptr = rd_ptr = 0, count = 0); rr_prio = IMEM; grant lock cleared.
- **Outputs during/after reset:**
  - arb_idle = 1; arb_unexp_resp = 0.
  - mem_req follows inputs combinationally, but is forced 0 while rst = 1.
  - *_resp = SCR1_MEM_RESP_NOTRDY and *_rdata = 0 whenever not routed.
- **Grant selection** (combinational), evaluated in this order:
  1. Lock held and locked master still requests → locked master.
  2. Only one master requests → that master.
  3. Both request → SCR1_ARB_DMEM_PRIO ? DMEM : master indicated by rr_prio.
- **Forwarding:**
  - mem_req = granted master's req & ~fifo_full.
  - mem_cmd/width/addr/wdata = granted master's fields.
  - When nothing is granted, mem_* data outputs are 0.
- **Accept:** accept = mem_req & mem_req_ack.
  - Only the granted master's *_req_ack = accept; the other master's ack = 0.
  - Zero added latency.
- **Full:** when count == SCR1_ARB_OUTST, mem_req = 0 and no ack to either master, even if a response pops in the same cycle. Acceptance resumes the next cycle.
- **Accept update:** on accept, push the owner ID at wr_ptr; rr_prio <= the other master; lock cleared.
- **Grant lock:** if mem_req = 1 & ~mem_req_ack, lock <= granted master.
  - Lock prevents a grant switch while a request is stalled.
  - Lock is released when the locked master deasserts req or its request is accepted.
- **Response routing:** resp_valid = mem_resp != SCR1_MEM_RESP_NOTRDY.
  - If FIFO not empty: head owner gets *_resp = mem_resp and *_rdata = mem_rdata; the other master gets NOTRDY/0; pop at the clock edge.
  - If FIFO empty: response discarded; arb_unexp_resp = 1 for that cycle.
- **Simultaneous push and pop** (not full): both occur; count unchanged.
- **Pointers:** wrap modulo SCR1_ARB_OUTST; count width is $clog2(SCR1_ARB_OUTST)+1.
- **arb_idle:** arb_idle = (count == 0).
- **Reset mid-operation:** FIFO contents discarded. The bridge must be reset in the same cycle; any stale response afterwards is flagged via arb_unexp_resp and not routed.
- **Widths:** no data alignment or modification; pure pass-through.

Test Plan:
- **Single IMEM read:** imem_req=1, addr=0x100, mem_req_ack=1 → imem_req_ack=1 same cycle; 2 cycles later mem_resp=RDY_OK, rdata=0xDEADBEEF → imem_resp=RDY_OK, imem_rdata=0xDEADBEEF, dmem_resp=NOTRDY; arb_idle returns to 1.
- **Round-robin contention:** both request continuously, mem_req_ack=1 every cycle, DMEM_PRIO=0 → grants I,D,I,D; responses return to owners in that order.
- **Stall lock:** DMEM granted with mem_req_ack=0 for 3 cycles while IMEM also requests → mem_addr stays at the DMEM address; DMEM is acked on cycle 4; IMEM is granted the next cycle.
- **FIFO full:** 4 accepts with no responses → mem_req=0, both acks 0. On the cycle a response pops, still no accept; accept occurs the following cycle.
- **Unexpected response:** after reset, mem_resp=RDY_ER with the FIFO empty → arb_unexp_resp=1 for one cycle; both *_resp=NOTRDY.
- **Mid-operation reset:** rst=1 with 2 requests outstanding → next cycle arb_idle=1, mem_req=0; rr_prio favours IMEM.
